// File: rtl/id_decode_stage.sv
// id_decode_stage: MIPS-style instruction decode stage.
// Holds the 32 x 32 register file with write-through bypass, decodes the
// opcode into WB/M/EX control groups and registers everything into the ID/EX
// pipeline latch every cycle.
// Optional feature macro: LOAD_USE_STALL_EN
//   defined   -> load-use hazard detection drives 'stall' and inserts a bubble
//   undefined -> 'stall' is tied low and no hazard logic is built
module id_decode_stage #(
    parameter logic [31:0] RF_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_ID_INSTR,
    input  logic [31:0] IF_ID_NPC,
    input  logic        flush,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_WriteReg,
    input  logic [31:0] MEM_WB_WriteData,
    output logic        stall,
    output logic [1:0]  ID_EX_WB,
    output logic [2:0]  ID_EX_M,
    output logic [3:0]  ID_EX_EX,
    output logic [31:0] ID_EX_NPC,
    output logic [31:0] ID_EX_RD1,
    output logic [31:0] ID_EX_RD2,
    output logic [31:0] ID_EX_IMM,
    output logic [4:0]  ID_EX_RT,
    output logic [4:0]  ID_EX_RD
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Control word layout: {WB[1:0], M[2:0], EX[3:0]}
    function automatic logic [8:0] decode_ctrl(input logic [5:0] op);
        logic [8:0] ctl;
        case (op)
            OP_RTYPE: ctl = {2'b10, 3'b000, 4'b1100};
            OP_LW:    ctl = {2'b11, 3'b010, 4'b0001};
            OP_SW:    ctl = {2'b00, 3'b001, 4'b0001};
            OP_BEQ:   ctl = {2'b00, 3'b100, 4'b0010};
            default:  ctl = 9'd0;
        endcase
        return ctl;
    endfunction

    logic [31:0] r_rf [0:31];
    logic [1:0]  r_wb;
    logic [2:0]  r_m;
    logic [3:0]  r_ex;
    logic [31:0] r_npc;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;

    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [8:0]  w_dec;
    logic [8:0]  w_ctl;
    logic [31:0] w_imm;
    logic        w_stall;
    logic        w_wr_en;

    assign w_rs_idx = IF_ID_INSTR[25:21];
    assign w_rt_idx = IF_ID_INSTR[20:16];
    assign w_dec    = decode_ctrl(IF_ID_INSTR[31:26]);
    assign w_imm    = {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};
    assign w_wr_en  = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

    // Register file: r0 stays zero, r1..r31 reset to RF_INIT; writes ignore stall/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf[0] <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                r_rf[i] <= RF_INIT;
            end
        end else begin
            r_rf[0] <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                if (w_wr_en && (MEM_WB_WriteReg == 5'(i))) begin
                    r_rf[i] <= MEM_WB_WriteData;
                end else begin
                    r_rf[i] <= r_rf[i];
                end
            end
        end
    end

    // rs read port: r0 reads zero, same-cycle writeback bypasses the array
    always_comb begin
        w_rd1 = 32'd0;
        if (w_rs_idx == 5'd0) begin
            w_rd1 = 32'd0;
        end else if (w_wr_en && (MEM_WB_WriteReg == w_rs_idx)) begin
            w_rd1 = MEM_WB_WriteData;
        end else begin
            w_rd1 = r_rf[w_rs_idx];
        end
    end

    // rt read port: same rules as the rs port
    always_comb begin
        w_rd2 = 32'd0;
        if (w_rt_idx == 5'd0) begin
            w_rd2 = 32'd0;
        end else if (w_wr_en && (MEM_WB_WriteReg == w_rt_idx)) begin
            w_rd2 = MEM_WB_WriteData;
        end else begin
            w_rd2 = r_rf[w_rt_idx];
        end
    end

`ifdef LOAD_USE_STALL_EN
    // Load-use hazard: the load now in ID/EX targets a register this instruction reads.
    // Reset clears r_m asynchronously, so a pending stall drops immediately.
    always_comb begin
        w_stall = 1'b0;
        if (r_m[1] && (r_rt != 5'd0) && ((r_rt == w_rs_idx) || (r_rt == w_rt_idx))) begin
            w_stall = 1'b1;
        end else begin
            w_stall = 1'b0;
        end
    end

    // Control selection: flush wins, then a stall bubble, else the decoded controls
    always_comb begin
        w_ctl = 9'd0;
        if (flush) begin
            w_ctl = 9'd0;
        end else if (w_stall) begin
            w_ctl = 9'd0;
        end else begin
            w_ctl = w_dec;
        end
    end
`else
    assign w_stall = 1'b0;

    // Control selection: flush squashes, otherwise the decoded controls pass through
    always_comb begin
        w_ctl = 9'd0;
        if (flush) begin
            w_ctl = 9'd0;
        end else begin
            w_ctl = w_dec;
        end
    end
`endif

    assign stall = w_stall;

    // ID/EX pipeline latch: loads every cycle; data fields are never squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb  <= 2'd0;
            r_m   <= 3'd0;
            r_ex  <= 4'd0;
            r_npc <= 32'd0;
            r_rd1 <= 32'd0;
            r_rd2 <= 32'd0;
            r_imm <= 32'd0;
            r_rt  <= 5'd0;
            r_rd  <= 5'd0;
        end else begin
            r_wb  <= w_ctl[8:7];
            r_m   <= w_ctl[6:4];
            r_ex  <= w_ctl[3:0];
            r_npc <= IF_ID_NPC;
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
            r_imm <= w_imm;
            r_rt  <= IF_ID_INSTR[20:16];
            r_rd  <= IF_ID_INSTR[15:11];
        end
    end

    assign ID_EX_WB  = r_wb;
    assign ID_EX_M   = r_m;
    assign ID_EX_EX  = r_ex;
    assign ID_EX_NPC = r_npc;
    assign ID_EX_RD1 = r_rd1;
    assign ID_EX_RD2 = r_rd2;
    assign ID_EX_IMM = r_imm;
    assign ID_EX_RT  = r_rt;
    assign ID_EX_RD  = r_rd;

endmodule
